// File: rtl/mem_request_queue.sv
// mem_request_queue: consumer end of the parser output interface.
// Latches each strobed, non-NOP operation into an in-order circular queue.
// The queue decodes every address into DRAM bank group/bank/column/row
// fields. It tracks a saturating age per entry and presents the oldest
// entry to the DRAM command scheduler, which retires it with pop_s.
//
// Ports:
//   clk, rst_n         system clock (rising edge), async active-low reset
//   in_op_ready_s      parser strobe: in_opcode/in_address/in_time_cpu valid
//   in_opcode          0=DATA_READ 1=DATA_WRITE 2=OPCODE_FETCH 3=NOP
//   in_address         operation address
//   in_time_cpu        CPU cycle count at issue
//   pop_s              scheduler retires the head entry this cycle
//   queue_full/empty   count == QUEUE_SIZE / count == 0 (backpressure)
//   occupancy          current entry count
//   head_*             decoded fields of the oldest entry (NOP/0 when empty)
//   head_age/aged      cycles since head was written, saturating at AGE_MAX
//   overflow_err       sticky: a non-NOP strobe was dropped while full
module mem_request_queue #(
    parameter int unsigned QUEUE_SIZE    = 16,
    parameter int unsigned ADDRESS_WIDTH = 33,
    parameter int unsigned AGE_MAX       = 100
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_op_ready_s,
    input  logic [1:0]                   in_opcode,
    input  logic [ADDRESS_WIDTH-1:0]     in_address,
    input  logic [31:0]                  in_time_cpu,
    input  logic                         pop_s,
    output logic                         queue_full,
    output logic                         queue_empty,
    output logic [$clog2(QUEUE_SIZE):0]  occupancy,
    output logic                         head_valid,
    output logic [1:0]                   head_opcode,
    output logic [1:0]                   head_bank_group,
    output logic [1:0]                   head_bank,
    output logic [7:0]                   head_column,
    output logic [14:0]                  head_row,
    output logic [31:0]                  head_time_cpu,
    output logic [6:0]                   head_age,
    output logic                         head_aged,
    output logic                         overflow_err
);

    localparam int unsigned PtrW = $clog2(QUEUE_SIZE);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [1:0]      OpNop   = 2'd3;
    localparam logic [CntW-1:0] CntFull = CntW'(QUEUE_SIZE);
    localparam logic [6:0]      AgeMax  = 7'(AGE_MAX);

    logic [1:0]               op_mem   [QUEUE_SIZE];
    logic [ADDRESS_WIDTH-1:0] addr_mem [QUEUE_SIZE];
    logic [31:0]              time_mem [QUEUE_SIZE];
    logic [6:0]               age_q    [QUEUE_SIZE];
    logic [6:0]               age_d    [QUEUE_SIZE];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            overflow_q;
    logic            req, push, pop;

    assign req  = in_op_ready_s && (in_opcode != OpNop);
    // At full, a same-cycle pop frees the slot the push lands in.
    assign push = req && ((count_q != CntFull) || pop_s);
    // Empty queue: pop is ignored even when a push arrives alongside it.
    assign pop  = pop_s && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A slot is valid when its distance from rd_ptr is below the count.
    always_comb begin
        logic [PtrW-1:0] offset;
        offset = '0;
        for (int i = 0; i < QUEUE_SIZE; i++) begin
            age_d[i] = '0;
            offset   = PtrW'(i) - rd_ptr_q;
            if (({1'b0, offset} < count_q) && !(pop && (PtrW'(i) == rd_ptr_q))) begin
                age_d[i] = (age_q[i] >= AgeMax) ? AgeMax : age_q[i] + 7'd1;
            end
            if (push && (PtrW'(i) == wr_ptr_q)) begin
                age_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (req && (count_q == CntFull) && !pop_s) begin
                overflow_q <= 1'b1;
            end
            for (int i = 0; i < QUEUE_SIZE; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    // Payload needs no reset: it is only observed through a valid head.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]   <= in_opcode;
            addr_mem[wr_ptr_q] <= in_address;
            time_mem[wr_ptr_q] <= in_time_cpu;
        end
    end

    assign queue_full   = (count_q == CntFull);
    assign queue_empty  = (count_q == '0);
    assign occupancy    = count_q;
    assign head_valid   = !queue_empty;
    assign overflow_err = overflow_q;
    assign head_aged    = (head_age == AgeMax);

    always_comb begin
        head_opcode     = OpNop;
        head_bank_group = '0;
        head_bank       = '0;
        head_column     = '0;
        head_row        = '0;
        head_time_cpu   = '0;
        head_age        = '0;
        if (head_valid) begin
            head_opcode     = op_mem[rd_ptr_q];
            head_bank_group = addr_mem[rd_ptr_q][7:6];
            head_bank       = addr_mem[rd_ptr_q][9:8];
            head_column     = addr_mem[rd_ptr_q][17:10];
            head_row        = addr_mem[rd_ptr_q][32:18];
            head_time_cpu   = time_mem[rd_ptr_q];
            head_age        = age_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_mem_request_queue.sv
// Scoreboard bench for mem_request_queue: stimulus pushes expected entries,
// a negedge monitor pops and compares whenever the head is retired.
module tb_mem_request_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_op_ready_s = 1'b0;
    logic [1:0]  in_opcode = 2'd3;
    logic [32:0] in_address = '0;
    logic [31:0] in_time_cpu = '0;
    logic        pop_s = 1'b0;
    logic        queue_full, queue_empty, head_valid, head_aged, overflow_err;
    logic [4:0]  occupancy;
    logic [1:0]  head_opcode, head_bank_group, head_bank;
    logic [7:0]  head_column;
    logic [14:0] head_row;
    logic [31:0] head_time_cpu;
    logic [6:0]  head_age;

    mem_request_queue dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_op_ready_s   (in_op_ready_s),
        .in_opcode       (in_opcode),
        .in_address      (in_address),
        .in_time_cpu     (in_time_cpu),
        .pop_s           (pop_s),
        .queue_full      (queue_full),
        .queue_empty     (queue_empty),
        .occupancy       (occupancy),
        .head_valid      (head_valid),
        .head_opcode     (head_opcode),
        .head_bank_group (head_bank_group),
        .head_bank       (head_bank),
        .head_column     (head_column),
        .head_row        (head_row),
        .head_time_cpu   (head_time_cpu),
        .head_age        (head_age),
        .head_aged       (head_aged),
        .overflow_err    (overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [32:0] addr;
        logic [31:0] t;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   mcnt = 0;
    bit   movf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every retired head must equal the oldest expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && pop_s && head_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got head op %0h expected empty", head_opcode);
            end else begin
                e = exp_q.pop_front();
                chk("mon_opcode", head_opcode, e.op);
                chk("mon_bank_group", head_bank_group, e.addr[7:6]);
                chk("mon_bank", head_bank, e.addr[9:8]);
                chk("mon_column", head_column, e.addr[17:10]);
                chk("mon_row", head_row, e.addr[32:18]);
                chk("mon_time", head_time_cpu, e.t);
            end
        end
    end

    task automatic drive(input bit s, input logic [1:0] op, input logic [32:0] a,
                         input logic [31:0] t, input bit p);
        bit acc;
        bit popok;
        in_op_ready_s = s;
        in_opcode     = op;
        in_address    = a;
        in_time_cpu   = t;
        pop_s         = p;
        acc   = s && (op != 2'd3) && ((mcnt < 16) || p);
        popok = p && (mcnt > 0);
        if (s && (op != 2'd3) && !acc) movf = 1'b1;
        if (acc) exp_q.push_back({op, a, t});
        mcnt = mcnt + (acc ? 1 : 0) - (popok ? 1 : 0);
        @(posedge clk);
        #1;
        in_op_ready_s = 1'b0;
        in_opcode     = 2'd3;
        pop_s         = 1'b0;
    endtask

    task automatic flags(input string tag);
        chk({tag, "_occupancy"}, occupancy, mcnt);
        chk({tag, "_full"}, queue_full, (mcnt == 16));
        chk({tag, "_empty"}, queue_empty, (mcnt == 0));
        chk({tag, "_head_valid"}, head_valid, (mcnt != 0));
        chk({tag, "_overflow"}, overflow_err, movf);
    endtask

    // Reset asserted mid-cycle; its effect must be visible before any edge.
    task automatic rst_pulse();
        #2;
        rst_n = 1'b0;
        in_op_ready_s = 1'b0;
        pop_s = 1'b0;
        exp_q.delete();
        mcnt = 0;
        movf = 1'b0;
        #1;
        chk("rst_occupancy", occupancy, 0);
        chk("rst_empty", queue_empty, 1);
        chk("rst_head_opcode", head_opcode, 2'd3);
        chk("rst_overflow", overflow_err, 0);
        chk("rst_head_valid", head_valid, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        flags("reset");
        chk("reset_head_opcode", head_opcode, 2'd3);
        chk("reset_head_age", head_age, 0);

        // Single write, hand-decoded fields of 0x14EA40.
        drive(1, 2'd1, 33'h14EA40, 32'd42, 0);
        chk("t1_head_valid", head_valid, 1);
        chk("t1_opcode", head_opcode, 2'd1);
        chk("t1_bank_group", head_bank_group, 2'd1);
        chk("t1_bank", head_bank, 2'd2);
        chk("t1_column", head_column, 8'h3A);
        chk("t1_row", head_row, 15'd5);
        chk("t1_time", head_time_cpu, 32'd42);
        chk("t1_occupancy", occupancy, 1);
        chk("t1_age", head_age, 0);
        drive(0, 2'd3, '0, '0, 1);
        flags("t1_after_pop");

        // NOP strobe and pop on empty queue are both ignored.
        drive(1, 2'd3, 33'h1234, 32'd7, 0);
        flags("t5_nop");
        chk("t5_nop_opcode", head_opcode, 2'd3);
        drive(0, 2'd3, '0, '0, 1);
        flags("t5_pop_empty");
        chk("t5_pop_opcode", head_opcode, 2'd3);

        // Aging saturates at 100.
        drive(1, 2'd2, 33'h1_0000_0000, 32'd99, 0);
        for (int k = 0; k <= 150; k++) begin
            chk("t4_age", head_age, (k < 100) ? k : 100);
            chk("t4_aged", head_aged, (k >= 100));
            if (k < 150) begin
                @(posedge clk);
                #1;
            end
        end
        chk("t4_row", head_row, 15'h4000);
        drive(0, 2'd3, '0, '0, 1);
        flags("t4_drained");

        // Fill, then overflow without pop.
        for (int i = 0; i < 16; i++) begin
            drive(1, 2'd0, 33'(i * 33'h400 + i), 32'(i), 0);
        end
        flags("t2_full");
        drive(1, 2'd0, 33'h1_FFFF_FFFF, 32'd999, 0);
        flags("t2_overflow");
        repeat (3) drive(0, 2'd3, '0, '0, 0);
        drive(0, 2'd3, '0, '0, 1);
        drive(0, 2'd3, '0, '0, 1);
        flags("t2_sticky");
        rst_pulse();
        flags("t2_after_reset");

        // Full queue with simultaneous strobe and pop for 20 cycles.
        for (int i = 0; i < 16; i++) begin
            drive(1, 2'd0, 33'(i * 33'h40000 + i * 33'h100), 32'(200 + i), 0);
        end
        flags("t3_full");
        for (int j = 0; j < 20; j++) begin
            drive(1, 2'd1, 33'(j * 33'h400 + j * 33'h40), 32'(100 + j), 1);
            flags("t3_pushpop");
        end
        drive(1, 2'd2, 33'h5555, 32'd555, 0);
        flags("t3_overflow");
        for (int i = 0; i < 11; i++) begin
            drive(0, 2'd3, '0, '0, 1);
        end
        flags("t6_five");

        // Mid-cycle reset with five entries and overflow set.
        rst_pulse();
        flags("t6_after_reset");
        drive(1, 2'd2, 33'h0ABC_DEF0, 32'd77, 0);
        chk("t6_head_valid", head_valid, 1);
        chk("t6_head_time", head_time_cpu, 32'd77);
        chk("t6_head_opcode", head_opcode, 2'd2);
        chk("t6_occupancy", occupancy, 1);
        drive(0, 2'd3, '0, '0, 1);
        flags("t6_drained");
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_request_queue.md
Name: mem_request_queue

Overview:
- Consumer end of the parser output interface: latches each strobed operation into a QUEUE_SIZE-deep in-order request queue.
- Asserts backpressure so the parser holds in WAITE while no slot is free.
- Decodes each address into DRAM bank group / bank / column / row fields.
- Tracks per-entry age and presents the oldest entry to the DRAM command scheduler, which retires it with a pop strobe.

Parameters:
- QUEUE_SIZE, 16, number of entries (power of two).
- ADDRESS_WIDTH, 33, request address width.
- AGE_MAX, 100, age saturation value; fits the 7-bit age counter type.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_op_ready_s  input  1  parser strobe: new operation valid this cycle.
- in_opcode  input  2  0=DATA_READ, 1=DATA_WRITE, 2=OPCODE_FETCH, 3=NOP.
- in_address  input  ADDRESS_WIDTH  operation address.
- in_time_cpu  input  32  CPU cycle count of issue.
- pop_s  input  1  scheduler retires head entry this cycle.
- queue_full  output  1  count == QUEUE_SIZE; parser must not strobe.
- queue_empty  output  1  count == 0.
- occupancy  output  $clog2(QUEUE_SIZE)+1  current entry count.
- head_valid  output  1  head entry present (= !queue_empty).
- head_opcode  output  2  head opcode; NOP when empty.
- head_bank_group  output  2  head address[7:6].
- head_bank  output  2  head address[9:8].
- head_column  output  8  head address[17:10].
- head_row  output  15  head address[32:18].
- head_time_cpu  output  32  head issue time.
- head_age  output  7  cycles since head entry was written, saturating.
- head_aged  output  1  head_age == AGE_MAX.
- overflow_err  output  1  sticky: strobe arrived while full with no pop.

Behaviour:
- Reset (async assert, sync release):
  - Write/read pointers, count, all ages and overflow_err clear to 0.
  - head_opcode = NOP; all other head fields 0; queue_empty = 1; queue_full = 0.
- Storage: circular buffer of {opcode, address, time_cpu, age}. Pointers are log2(QUEUE_SIZE) bits and wrap QUEUE_SIZE-1 -> 0. Count is tracked separately.
- Push condition: in_op_ready_s && in_opcode != NOP && (count < QUEUE_SIZE || pop_s).
  - On push, the entry is written at wr_ptr, its age is set to 0, and wr_ptr increments.
  - Strobes carrying NOP are discarded silently; count is unchanged.
- Overflow: in_op_ready_s with a non-NOP opcode while count == QUEUE_SIZE and !pop_s drops the operation and sets overflow_err, which holds until reset.
- Pop: pop_s with count > 0 advances rd_ptr. pop_s while empty is ignored.
- Simultaneous push and pop: both take effect and count is unchanged. At full, this accepts the new entry into the freed slot.
  - Pushing into an empty queue while pop_s is asserted pushes only; the pop is ignored.
- Count update each edge: +1 push only, -1 pop only, 0 both or neither.
- Latency: an entry pushed at edge N is at the head (if the queue was empty) with head_valid = 1 in the cycle after edge N.
- Head outputs are combinational decodes of the registered entry at rd_ptr. There is no bypass from the input to the head in the push cycle.
- Flags queue_full, queue_empty and occupancy are derived from the registered count.
- Age:
  - Every valid entry's age increments by 1 each cycle and saturates at AGE_MAX.
  - A newly written entry starts at 0 on the cycle after its push edge.
  - Invalid slots hold 0.
- Reset mid-operation discards all entries immediately; no partial state survives.

Test Plan:
- Single push of in_opcode=DATA_WRITE, in_address=33'h14EA40, in_time_cpu=42 -> next cycle: head_valid=1, head_bank_group=1, head_bank=2, head_column=8'h3A, head_row=5, head_time_cpu=42, occupancy=1.
- 16 consecutive READ strobes, then a 17th with pop_s=0 -> queue_full=1, occupancy=16, 17th dropped, overflow_err=1 and stays 1 until rst_n low.
- At full, strobe + pop_s same cycle, repeated 20 cycles -> occupancy stays 16, pointers wrap, head order matches push order, overflow_err=0.
- Push one entry, no pop for 150 cycles -> head_age counts 0..100, then holds 100; head_aged=1 from the 100th cycle after the push.
- NOP strobe into empty queue, then pop_s on empty -> occupancy=0, head_opcode=NOP, head_valid=0 throughout.
- 5 entries queued, rst_n pulsed low mid-cycle -> immediately occupancy=0, queue_empty=1, head_opcode=NOP, overflow_err=0; first push after release appears at head.
